ldpc_iter_ctrl: RTL and testbench
=================================

Name: ldpc_iter_ctrl

Overview:
- Iteration/schedule controller for the layered LDPC decoder; successor to the fixed-count data-iteration counter.
- Runs one frame per start request:
  - steps a layer index through NUM_LAYERS layers per iteration;
  - counts iterations up to a run-time maximum;
  - terminates early on a zero-syndrome report;
  - drains the datapath pipeline;
  - holds a done/ack handshake with the frame sequencer.
- Sits between the frame sequencer and the check/variable node datapath.

Parameters:
- NUM_LAYERS, 12, layers per decoding iteration (>=2).
- LOG2_LAYERS, 4, width of layer_idx; 2^LOG2_LAYERS >= NUM_LAYERS.
- LOG2_ITER, 6, width of iteration count and max_iter.
- DRAIN_CYCLES, 3, pipeline flush cycles before DONE (>=1).
- LOG2_DRAIN, 2, width of drain counter; 2^LOG2_DRAIN > DRAIN_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  frame start request; honoured only in IDLE.
- max_iter  in  LOG2_ITER  maximum iterations; sampled on accepted start.
- layer_en  in  1  datapath advance enable; 0 stalls layer stepping.
- syn_valid  in  1  syndrome result strobe.
- syn_ok  in  1  syndrome all-zero, qualified by syn_valid.
- abort  in  1  cancel current frame.
- done_ack  in  1  sequencer acknowledge of done.
- layer_idx  out  LOG2_LAYERS  current layer.
- iter_count  out  LOG2_ITER  completed iterations.
- state  out  2  0=IDLE, 1=RUN, 2=DRAIN, 3=DONE.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- converged  out  1  frame ended on syndrome success; valid in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - layer_idx=0, iter_count=0, converged=0.
  - Internal max register=1, drain counter=0.
- IDLE:
  - start=1 -> RUN next cycle.
  - On the same edge: layer_idx=0, iter_count=0, converged=0.
  - max register = max_iter, or 1 if max_iter==0.
- RUN, layer_en=1:
  - layer_idx<NUM_LAYERS-1 -> layer_idx+1.
  - layer_idx==NUM_LAYERS-1 -> layer_idx=0, iter_count+1.
  - If the new iter_count equals the max register -> DRAIN.
- RUN, layer_en=0: layer_idx and iter_count hold.
- RUN, syn_valid=1 and syn_ok=1:
  - -> DRAIN, converged=1.
  - layer_idx and iter_count freeze at current values; a simultaneous wrap increment is still applied.
  - Syndrome priority over max reached: converged=1 if both occur in the same cycle.
- syn_valid=1 with syn_ok=0: no effect. syn_valid outside RUN: ignored.
- DRAIN:
  - Drain counter increments each cycle regardless of layer_en.
  - After exactly DRAIN_CYCLES cycles in DRAIN -> DONE; counter clears.
- DONE:
  - Holds, with done=1, until done_ack=1; then -> IDLE.
  - start in the same cycle as done_ack is not accepted; a new frame needs start in IDLE.
- abort:
  - In RUN or DRAIN -> IDLE next cycle; converged=0, done never asserted.
  - Ignored in IDLE and DONE.
  - abort has priority over every other event.
- start outside IDLE: ignored. max_iter changes after start: no effect.
- Outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Latency:
  - start to RUN: 1 cycle.
  - Unstalled frame, no convergence: start accepted at edge 0, DONE entered at edge NUM_LAYERS*max + DRAIN_CYCLES.

Decomposition:
- Shared package ldpc_ctrl_pkg holds:
  - state encoding constants IDLE/RUN/DRAIN/DONE (0..3), shared with the frame sequencer;
  - the default NUM_LAYERS and LOG2_ITER values.
- Natural sub-module: ldpc_layer_counter.
  - Layer index with enable and wrap.
  - Emits a one-cycle wrap pulse; the controller FSM counts iterations on that pulse.

Test Plan:
- Reset mid-RUN:
  - drive rst=0 asynchronously between edges;
  - -> state=0, layer_idx=0, iter_count=0, busy=0 immediately, before the next clk edge.
- Full run, defaults, max_iter=2, layer_en=1:
  - -> state=1 for 24 cycles, state=2 for 3 cycles, then done=1, converged=0, iter_count=2.
  - Hold done_ack=0 for 5 cycles -> done stays 1. Pulse done_ack -> IDLE.
- Early termination, max_iter=10:
  - syn_valid=syn_ok=1 at iter_count=3, layer_idx=5;
  - -> DRAIN next cycle, counts frozen at 3/5, DONE with converged=1.
- Stall, max_iter=1, layer_en toggling 1/0 every cycle:
  - -> 24 cycles in RUN;
  - layer_idx holds on every cycle with layer_en=0.
- Boundaries:
  - max_iter=0 -> exactly one iteration (12 layer steps).
  - Syndrome success coincident with the final wrap at max_iter=1 -> converged=1, iter_count=1.
- Abort in DRAIN -> IDLE next cycle, no done pulse. A start asserted in RUN is ignored; iter_count does not reset.

Source files
------------

// File: rtl/ldpc_ctrl_pkg.sv
// rtl/ldpc_ctrl_pkg.sv - shared state encoding and defaults for the LDPC iteration controller
`timescale 1ns/1ps
package ldpc_ctrl_pkg;

   // Encoding is shared with the frame sequencer, so the values are fixed
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

   localparam int DEF_NUM_LAYERS = 12;
   localparam int DEF_LOG2_ITER  = 6;

endpackage

// File: rtl/ldpc_layer_counter.sv
// rtl/ldpc_layer_counter.sv - layer index counter with enable, clear and wrap pulse
`timescale 1ns/1ps
module ldpc_layer_counter
   import ldpc_ctrl_pkg::*;
#(
   parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
   parameter int LOG2_LAYERS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   en,
   output logic [LOG2_LAYERS-1:0] layer_idx,
   output logic                   at_last,
   output logic                   wrap
);

   logic [LOG2_LAYERS-1:0] layer_q;
   logic [LOG2_LAYERS-1:0] layer_d;

   assign at_last   = (layer_q == LOG2_LAYERS'(NUM_LAYERS - 1));
   // Combinational so the iteration count moves on the same edge as the wrap
   assign wrap      = en && at_last && !clr;
   assign layer_idx = layer_q;

   // Next layer: clear wins, otherwise step and wrap to zero after the last layer
   always_comb begin
      layer_d = layer_q;
      if (clr) begin
         layer_d = '0;
      end else if (en) begin
         layer_d = at_last ? '0 : layer_q + LOG2_LAYERS'(1);
      end
   end

   // Layer index register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         layer_q <= '0;
      end else begin
         layer_q <= layer_d;
      end
   end

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// rtl/ldpc_iter_ctrl.sv - iteration/schedule controller for the layered LDPC decoder
`timescale 1ns/1ps
module ldpc_iter_ctrl
   import ldpc_ctrl_pkg::*;
#(
   parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
   parameter int LOG2_LAYERS  = 4,
   parameter int LOG2_ITER    = DEF_LOG2_ITER,
   parameter int DRAIN_CYCLES = 3,
   parameter int LOG2_DRAIN   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [LOG2_ITER-1:0]   max_iter,
   input  logic                   layer_en,
   input  logic                   syn_valid,
   input  logic                   syn_ok,
   input  logic                   abort,
   input  logic                   done_ack,
   output logic [LOG2_LAYERS-1:0] layer_idx,
   output logic [LOG2_ITER-1:0]   iter_count,
   output logic [1:0]             state,
   output logic                   busy,
   output logic                   done,
   output logic                   converged
);

   ctrl_state_e            state_q, state_d;
   logic [LOG2_ITER-1:0]   iter_q, iter_d;
   logic [LOG2_ITER-1:0]   max_q, max_d;
   logic [LOG2_DRAIN-1:0]  drain_q, drain_d;
   logic                   conv_q, conv_d;
   logic                   cnt_clr, cnt_en;
   logic                   at_last, wrap;
   logic                   syn_hit;

   assign syn_hit = syn_valid && syn_ok;

   ldpc_layer_counter #(
      .NUM_LAYERS  (NUM_LAYERS),
      .LOG2_LAYERS (LOG2_LAYERS)
   ) u_layer_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .layer_idx (layer_idx),
      .at_last   (at_last),
      .wrap      (wrap)
   );

   // Frame FSM next state: abort beats syndrome, syndrome beats max-iteration
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      max_d   = max_q;
      drain_d = drain_q;
      conv_d  = conv_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               iter_d  = '0;
               conv_d  = 1'b0;
               max_d   = (max_iter == '0) ? LOG2_ITER'(1) : max_iter;
               cnt_clr = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               conv_d  = 1'b0;
            end else begin
               // A syndrome hit freezes the layer unless it lands on the wrap step
               cnt_en = layer_en && (!syn_hit || at_last);
               if (wrap) begin
                  iter_d = iter_q + LOG2_ITER'(1);
               end
               if (syn_hit) begin
                  state_d = DRAIN;
                  conv_d  = 1'b1;
               end else if (wrap && (iter_d == max_q)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
               conv_d  = 1'b0;
               drain_d = '0;
            end else if (drain_q == LOG2_DRAIN'(DRAIN_CYCLES - 1)) begin
               state_d = DONE;
               drain_d = '0;
            end else begin
               drain_d = drain_q + LOG2_DRAIN'(1);
            end
         end
         DONE: begin
            if (done_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         iter_q  <= '0;
         max_q   <= LOG2_ITER'(1);
         drain_q <= '0;
         conv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         max_q   <= max_d;
         drain_q <= drain_d;
         conv_q  <= conv_d;
      end
   end

   assign state      = state_q;
   assign iter_count = iter_q;
   assign converged  = conv_q;
   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb/tb_ldpc_iter_ctrl.sv - self-checking bench for ldpc_iter_ctrl
`timescale 1ns/1ps
module tb_ldpc_iter_ctrl;

   localparam int NL = 12;
   localparam int DC = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [5:0] max_iter = '0;
   logic       layer_en = 1'b0;
   logic       syn_valid = 1'b0;
   logic       syn_ok = 1'b0;
   logic       abort = 1'b0;
   logic       done_ack = 1'b0;
   logic [3:0] layer_idx;
   logic [5:0] iter_count;
   logic [1:0] state;
   logic       busy;
   logic       done;
   logic       converged;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: progress tracked as total layer steps in the frame
   int m_state;
   int m_steps;
   int m_max;
   int m_drain;
   bit m_conv;

   always #5 clk = ~clk;

   ldpc_iter_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .max_iter   (max_iter),
      .layer_en   (layer_en),
      .syn_valid  (syn_valid),
      .syn_ok     (syn_ok),
      .abort      (abort),
      .done_ack   (done_ack),
      .layer_idx  (layer_idx),
      .iter_count (iter_count),
      .state      (state),
      .busy       (busy),
      .done       (done),
      .converged  (converged)
   );

   function automatic void model_reset();
      m_state = 0;
      m_steps = 0;
      m_max   = 1;
      m_drain = 0;
      m_conv  = 1'b0;
   endfunction

   function automatic void model_step();
      case (m_state)
         0: if (start) begin
            m_state = 1;
            m_steps = 0;
            m_conv  = 1'b0;
            m_max   = (max_iter == 0) ? 1 : int'(max_iter);
         end
         1: if (abort) begin
            m_state = 0;
            m_conv  = 1'b0;
         end else if (syn_valid && syn_ok) begin
            if (layer_en && (m_steps % NL == NL - 1)) m_steps++;
            m_state = 2;
            m_drain = DC;
            m_conv  = 1'b1;
         end else if (layer_en) begin
            m_steps++;
            if (m_steps == m_max * NL) begin
               m_state = 2;
               m_drain = DC;
            end
         end
         2: if (abort) begin
            m_state = 0;
            m_conv  = 1'b0;
         end else begin
            m_drain--;
            if (m_drain == 0) m_state = 3;
         end
         default: if (done_ack) m_state = 0;
      endcase
   endfunction

   task automatic tick();
      if (!rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_done();
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
   endtask

   task automatic begin_frame(input logic [5:0] mi);
      max_iter = mi;
      layer_en = 1'b1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_tests++;
      if (state !== 2'd0 || layer_idx !== 4'd0 || iter_count !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_async: state=%0d layer=%0d iter=%0d, want 0/0/0", state, layer_idx, iter_count);
      end
      tick();
      tick();
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b done=%b conv=%b, want 0/0/0", busy, done, converged);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_release: state=%0d, want 0", state);
      end
   endtask

   task automatic test_full_run();
      int run_c, drn_c;
      begin_frame(6'd2);
      run_c = 0;
      while (state === 2'd1 && run_c < 200) begin run_c++; tick(); end
      n_tests++;
      if (run_c != 2 * NL) begin
         n_fail++;
         $display("FAIL full_run_cycles: got %0d, want %0d", run_c, 2 * NL);
      end
      drn_c = 0;
      while (state === 2'd2 && drn_c < 50) begin drn_c++; tick(); end
      n_tests++;
      if (drn_c != DC) begin
         n_fail++;
         $display("FAIL full_drain_cycles: got %0d, want %0d", drn_c, DC);
      end
      n_tests++;
      if (done !== 1'b1 || converged !== 1'b0 || iter_count !== 6'd2 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_done: done=%b conv=%b iter=%0d busy=%b, want 1/0/2/0", done, converged, iter_count, busy);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done_hold: cycle %0d done=%b, want 1", i, done);
         end
      end
      ack_done();
      n_tests++;
      if (state !== 2'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ack: state=%0d done=%b, want 0/0", state, done);
      end
   endtask

   task automatic test_early_term();
      int w;
      begin_frame(6'd10);
      w = 0;
      while (!(iter_count === 6'd3 && layer_idx === 4'd5) && w < 1000) begin w++; tick(); end
      n_tests++;
      if (w >= 1000) begin
         n_fail++;
         $display("FAIL early_reach: timeout iter=%0d layer=%0d, want 3/5", iter_count, layer_idx);
      end
      syn_valid = 1'b1;
      syn_ok    = 1'b1;
      tick();
      syn_valid = 1'b0;
      syn_ok    = 1'b0;
      n_tests++;
      if (state !== 2'd2 || iter_count !== 6'd3 || layer_idx !== 4'd5) begin
         n_fail++;
         $display("FAIL early_drain: state=%0d iter=%0d layer=%0d, want 2/3/5", state, iter_count, layer_idx);
      end
      w = 0;
      while (state === 2'd2 && w < 50) begin w++; tick(); end
      n_tests++;
      if (state !== 2'd3 || converged !== 1'b1 || iter_count !== 6'd3 || layer_idx !== 4'd5) begin
         n_fail++;
         $display("FAIL early_done: state=%0d conv=%b iter=%0d layer=%0d, want 3/1/3/5", state, converged, iter_count, layer_idx);
      end
      ack_done();
   endtask

   task automatic test_stall();
      int run_c;
      logic [3:0] prev;
      begin_frame(6'd1);
      run_c = 0;
      while (state === 2'd1 && run_c < 200) begin
         layer_en = (run_c % 2 == 1);
         prev = layer_idx;
         tick();
         if (run_c % 2 == 0) begin
            n_tests++;
            if (state === 2'd1 && layer_idx !== prev) begin
               n_fail++;
               $display("FAIL stall_hold: layer=%0d, want %0d", layer_idx, prev);
            end
         end
         run_c++;
      end
      layer_en = 1'b1;
      n_tests++;
      if (run_c != 2 * NL) begin
         n_fail++;
         $display("FAIL stall_cycles: got %0d, want %0d", run_c, 2 * NL);
      end
      while (state !== 2'd3 && run_c < 300) begin run_c++; tick(); end
      ack_done();
   endtask

   task automatic test_max_zero();
      int run_c, w;
      begin_frame(6'd0);
      run_c = 0;
      while (state === 2'd1 && run_c < 200) begin run_c++; tick(); end
      n_tests++;
      if (run_c != NL) begin
         n_fail++;
         $display("FAIL maxzero_cycles: got %0d, want %0d", run_c, NL);
      end
      w = 0;
      while (state !== 2'd3 && w < 50) begin w++; tick(); end
      n_tests++;
      if (done !== 1'b1 || iter_count !== 6'd1 || converged !== 1'b0) begin
         n_fail++;
         $display("FAIL maxzero_done: done=%b iter=%0d conv=%b, want 1/1/0", done, iter_count, converged);
      end
      ack_done();
   endtask

   task automatic test_syn_on_wrap();
      int w;
      begin_frame(6'd1);
      w = 0;
      while (layer_idx !== 4'd11 && w < 100) begin w++; tick(); end
      syn_valid = 1'b1;
      syn_ok    = 1'b1;
      tick();
      syn_valid = 1'b0;
      syn_ok    = 1'b0;
      n_tests++;
      if (state !== 2'd2 || iter_count !== 6'd1 || layer_idx !== 4'd0) begin
         n_fail++;
         $display("FAIL wrapsyn_drain: state=%0d iter=%0d layer=%0d, want 2/1/0", state, iter_count, layer_idx);
      end
      w = 0;
      while (state !== 2'd3 && w < 50) begin w++; tick(); end
      n_tests++;
      if (converged !== 1'b1 || iter_count !== 6'd1) begin
         n_fail++;
         $display("FAIL wrapsyn_done: conv=%b iter=%0d, want 1/1", converged, iter_count);
      end
      ack_done();
   endtask

   task automatic test_abort_drain();
      int w, seen;
      begin_frame(6'd1);
      w = 0;
      while (state === 2'd1 && w < 100) begin w++; tick(); end
      n_tests++;
      if (state !== 2'd2) begin
         n_fail++;
         $display("FAIL abort_pre: state=%0d, want 2", state);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_tests++;
      if (state !== 2'd0 || busy !== 1'b0 || converged !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: state=%0d busy=%b conv=%b, want 0/0/0", state, busy, converged);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL abort_nodone: done seen %0d times, want 0", seen);
      end
   endtask

   task automatic test_start_in_run();
      int w;
      begin_frame(6'd3);
      w = 0;
      while (!(iter_count === 6'd1 && layer_idx === 4'd4) && w < 100) begin w++; tick(); end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_tests++;
      if (state !== 2'd1 || iter_count !== 6'd1 || layer_idx !== 4'd5) begin
         n_fail++;
         $display("FAIL start_in_run: state=%0d iter=%0d layer=%0d, want 1/1/5", state, iter_count, layer_idx);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      begin_frame(6'd2);
      for (int i = 0; i < 15; i++) tick();
      #3;
      rst = 1'b0;
      #1;
      n_tests++;
      if (state !== 2'd0 || layer_idx !== 4'd0 || iter_count !== 6'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_run: state=%0d layer=%0d iter=%0d busy=%b, want 0/0/0/0", state, layer_idx, iter_count, busy);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_random();
      int errs;
      logic [1:0] e_state;
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 7) == 0);
         max_iter  = 6'($urandom_range(0, 3));
         layer_en  = ($urandom_range(0, 3) != 0);
         syn_valid = ($urandom_range(0, 31) == 0);
         syn_ok    = $urandom_range(0, 1) == 1;
         abort     = ($urandom_range(0, 99) == 0);
         done_ack  = ($urandom_range(0, 3) == 0);
         tick();
         e_state = 2'(m_state);
         n_tests++;
         if (state !== e_state || layer_idx !== 4'(m_steps % NL) || iter_count !== 6'(m_steps / NL) ||
             converged !== m_conv || busy !== (m_state == 1 || m_state == 2) || done !== (m_state == 3)) begin
            n_fail++;
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle%0d: state=%0d layer=%0d iter=%0d conv=%b busy=%b done=%b, want %0d/%0d/%0d/%b",
                        c, state, layer_idx, iter_count, converged, busy, done,
                        m_state, m_steps % NL, m_steps / NL, m_conv);
         end
      end
      start = 1'b0; syn_valid = 1'b0; syn_ok = 1'b0; abort = 1'b0; done_ack = 1'b0; layer_en = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_run();
      test_early_term();
      test_stall();
      test_max_zero();
      test_syn_on_wrap();
      test_abort_drain();
      test_start_in_run();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
